lsq_head_drainer: RTL and testbench

- Reader/drain side of the load-store queue storage.
- Watches the LSQ head entry and, once it is eligible, issues one data-cache request with a valid/ready handshake, then waits for the cache response.
- For loads, returns byte-aligned, extended data to writeback. For every completed access, pulses `deq_valid` to retire the head entry.
- One access in flight at a time, in strict program order.

---
 rtl/lsq_head_drainer_if.sv | 36 +++
 rtl/lsq_head_drainer.sv | 159 +++++++++++++++
 tb/tb_lsq_head_drainer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_head_drainer_if.sv
// Data-cache request/response bundle between the LSQ drainer and the D$.
// Ports: dc_req_* request handshake (valid/ready), dc_resp_* one-cycle response.
interface lsq_head_drainer_if #(
    parameter int ADDR_W = 32
);
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_we;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [31:0]       dc_req_wdata;
    logic [3:0]        dc_req_wmask;
    logic              dc_resp_valid;
    logic [31:0]       dc_resp_rdata;

    modport master (
        output dc_req_valid,
        output dc_req_we,
        output dc_req_addr,
        output dc_req_wdata,
        output dc_req_wmask,
        input  dc_req_ready,
        input  dc_resp_valid,
        input  dc_resp_rdata
    );

    modport slave (
        input  dc_req_valid,
        input  dc_req_we,
        input  dc_req_addr,
        input  dc_req_wdata,
        input  dc_req_wmask,
        output dc_req_ready,
        output dc_resp_valid,
        output dc_resp_rdata
    );
endinterface

// File: rtl/lsq_head_drainer.sv
// Drains the LSQ head: one D$ access at a time, load writeback, retire pulse.
// Ports: clk/rst_aH, flush, head_* entry view, deq_valid, dc (D$ bus), wb_*, busy.
module lsq_head_drainer #(
    parameter int ADDR_W   = 32,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk,
    input  logic                rst_aH,
    input  logic                flush,
    input  logic                head_valid,
    input  logic                head_is_store,
    input  logic                head_addr_valid,
    input  logic                head_st_committed,
    input  logic [ADDR_W-1:0]   head_addr,
    input  logic [31:0]         head_st_data,
    input  logic [1:0]          head_size,
    input  logic                head_sign_ext,
    input  logic [ROB_ID_W-1:0] head_rob_id,
    output logic                deq_valid,
    lsq_head_drainer_if.master  dc,
    output logic                wb_valid,
    output logic [ROB_ID_W-1:0] wb_rob_id,
    output logic [31:0]         wb_data,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                is_store_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         st_data_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [ROB_ID_W-1:0] rob_q;

    logic        eligible;
    logic        launch;
    logic        retire;
    logic        in_req;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic [3:0]  base_mask;
    logic [31:0] r;
    logic [31:0] ld_ext;

    // deq_valid gate keeps the not-yet-popped head from relaunching
    assign eligible = head_valid && head_addr_valid
                   && (!head_is_store || head_st_committed)
                   && !flush && !deq_valid;

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = REQ;
                    launch  = 1'b1;
                end
            end
            REQ: begin
                if (dc.dc_req_ready)
                    state_d = flush ? DRAIN : RESP;
                else if (flush)
                    state_d = IDLE;
            end
            RESP: begin
                // a flush coinciding with the response ends the access
                // silently; the LSQ is clearing itself anyway
                if (dc.dc_resp_valid) begin
                    state_d = IDLE;
                    retire  = !flush;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dc.dc_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign off = addr_q[1:0];
    assign sh  = {off, 3'b000};

    always_comb begin
        unique case (size_q)
            2'd0:    base_mask = 4'b0001;
            2'd1:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    assign r = dc.dc_resp_rdata >> sh;

    always_comb begin
        unique case (size_q)
            2'd0:    ld_ext = {{24{sext_q & r[7]}}, r[7:0]};
            2'd1:    ld_ext = {{16{sext_q & r[15]}}, r[15:0]};
            default: ld_ext = r;
        endcase
    end

    // request fields shown only while requesting, so idle/reset reads 0
    assign in_req          = (state_q == REQ);
    assign dc.dc_req_valid = in_req;
    assign dc.dc_req_we    = in_req & is_store_q;
    assign dc.dc_req_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00}
                                    : '0;
    assign dc.dc_req_wmask = in_req ? 4'(base_mask << off) : 4'b0;
    assign dc.dc_req_wdata = in_req ? (st_data_q << sh) : 32'b0;
    assign busy            = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            is_store_q <= 1'b0;
            addr_q     <= '0;
            st_data_q  <= '0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            rob_q      <= '0;
            deq_valid  <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rob_id  <= '0;
            wb_data    <= '0;
        end else begin
            if (launch) begin
                is_store_q <= head_is_store;
                addr_q     <= head_addr;
                st_data_q  <= head_st_data;
                size_q     <= head_size;
                sext_q     <= head_sign_ext;
                rob_q      <= head_rob_id;
            end
            deq_valid <= retire;
            wb_valid  <= retire && !is_store_q;
            if (retire && !is_store_q) begin
                wb_rob_id <= rob_q;
                wb_data   <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsq_head_drainer.sv
// Self-checking bench for lsq_head_drainer: vector table plus corner sequences.
// Loads push expected writeback to a queue; a monitor pops on wb_valid.
module tb_lsq_head_drainer;

    logic        clk;
    logic        rst_aH;
    logic        flush;
    logic        head_valid;
    logic        head_is_store;
    logic        head_addr_valid;
    logic        head_st_committed;
    logic [31:0] head_addr;
    logic [31:0] head_st_data;
    logic [1:0]  head_size;
    logic        head_sign_ext;
    logic [4:0]  head_rob_id;
    logic        deq_valid;
    logic        wb_valid;
    logic [4:0]  wb_rob_id;
    logic [31:0] wb_data;
    logic        busy;

    lsq_head_drainer_if #(.ADDR_W(32)) dc ();

    lsq_head_drainer #(.ADDR_W(32), .ROB_ID_W(5)) dut (
        .clk               (clk),
        .rst_aH            (rst_aH),
        .flush             (flush),
        .head_valid        (head_valid),
        .head_is_store     (head_is_store),
        .head_addr_valid   (head_addr_valid),
        .head_st_committed (head_st_committed),
        .head_addr         (head_addr),
        .head_st_data      (head_st_data),
        .head_size         (head_size),
        .head_sign_ext     (head_sign_ext),
        .head_rob_id       (head_rob_id),
        .deq_valid         (deq_valid),
        .dc                (dc),
        .wb_valid          (wb_valid),
        .wb_rob_id         (wb_rob_id),
        .wb_data           (wb_data),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] st_data;
        logic [1:0]  size;
        logic        sext;
        logic [4:0]  rob;
        logic [31:0] rdata;
        int          commit_wait;
        int          ready_lag;
        int          resp_lag;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        logic [4:0]  rob;
        logic [31:0] data;
    } wb_t;

    vec_t vecs[11];
    wb_t  sbq[$];
    wb_t  got;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_aH && wb_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got rob %0d data %h expected none",
                         wb_rob_id, wb_data);
            end else begin
                got = sbq.pop_front();
                chk("wb_rob_id", 32'(wb_rob_id), 32'(got.rob));
                chk("wb_data", wb_data, got.data);
            end
        end
    end

    task automatic set_head(logic st, logic [31:0] a, logic [31:0] d,
                            logic [1:0] sz, logic sx, logic [4:0] rob);
        head_is_store = st;
        head_addr     = a;
        head_st_data  = d;
        head_size     = sz;
        head_sign_ext = sx;
        head_rob_id   = rob;
        head_valid    = 1'b1;
        head_addr_valid = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dc.dc_req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no dc_req_valid expected one");
        end
    endtask

    task automatic do_access(vec_t v);
        bit ok;
        set_head(v.is_store, v.addr, v.st_data, v.size, v.sext, v.rob);
        head_st_committed = (v.commit_wait == 0);
        dc.dc_req_ready = (v.ready_lag == 0);
        for (int i = 0; i < v.commit_wait; i++) begin
            @(negedge clk);
            chk("no_req_uncommitted", 32'(dc.dc_req_valid), 0);
        end
        head_st_committed = 1'b1;
        wait_req(ok);
        if (!ok) return;
        head_valid = 1'b0;
        chk("req_addr", dc.dc_req_addr, v.exp_addr);
        chk("req_we", 32'(dc.dc_req_we), 32'(v.is_store));
        chk("req_wmask", 32'(dc.dc_req_wmask), 32'(v.exp_wmask));
        chk("req_wdata", dc.dc_req_wdata, v.exp_wdata);
        if (!v.is_store) sbq.push_back('{v.rob, v.exp_wb});
        for (int i = 0; i < v.ready_lag; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(dc.dc_req_valid), 1);
            chk("bp_addr", dc.dc_req_addr, v.exp_addr);
            chk("bp_wmask", 32'(dc.dc_req_wmask), 32'(v.exp_wmask));
            chk("bp_wdata", dc.dc_req_wdata, v.exp_wdata);
        end
        dc.dc_req_ready = 1'b1;
        @(negedge clk);
        chk("req_once", 32'(dc.dc_req_valid), 0);
        chk("busy_resp", 32'(busy), 1);
        dc.dc_req_ready = 1'b0;
        repeat (v.resp_lag - 1) @(negedge clk);
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = v.rdata;
        @(negedge clk);
        dc.dc_resp_valid = 1'b0;
        dc.dc_resp_rdata = 32'h5A5A5A5A;
        chk("deq_pulse", 32'(deq_valid), 1);
        chk("wb_valid_pulse", 32'(wb_valid), 32'(!v.is_store));
        chk("busy_done", 32'(busy), 0);
        @(negedge clk);
        chk("deq_one_cycle", 32'(deq_valid), 0);
        chk("wb_one_cycle", 32'(wb_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        // st addr data size sext rob rdata cw rl rsp exp_addr mask wdata wb
        vecs[0]  = '{0, 32'h100, 0, 2, 0, 3, 32'hDEADBEEF, 0, 0, 2,
                     32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{0, 32'h103, 0, 0, 1, 4, 32'h80000000, 0, 0, 1,
                     32'h100, 4'h8, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{0, 32'h103, 0, 0, 0, 5, 32'h80000000, 0, 0, 2,
                     32'h100, 4'h8, 32'h0, 32'h00000080};
        vecs[3]  = '{1, 32'h202, 32'h1234, 1, 0, 6, 0, 5, 0, 2,
                     32'h200, 4'hC, 32'h12340000, 0};
        vecs[4]  = '{1, 32'h10, 32'h0BADCAFE, 2, 0, 9, 0, 0, 3, 1,
                     32'h10, 4'hF, 32'h0BADCAFE, 0};
        vecs[5]  = '{0, 32'h102, 0, 1, 1, 10, 32'h80010000, 0, 0, 3,
                     32'h100, 4'hC, 32'h0, 32'hFFFF8001};
        vecs[6]  = '{1, 32'h101, 32'hFFFFFFAB, 0, 0, 11, 0, 0, 1, 1,
                     32'h100, 4'h2, 32'hFFFFAB00, 0};
        vecs[7]  = '{1, 32'h8, 32'hCAFEF00D, 2, 0, 12, 0, 0, 0, 2,
                     32'h8, 4'hF, 32'hCAFEF00D, 0};
        vecs[8]  = '{0, 32'h0, 0, 3, 1, 13, 32'h12345678, 0, 0, 1,
                     32'h0, 4'hF, 32'h0, 32'h12345678};
        vecs[9]  = '{0, 32'h103, 0, 1, 0, 14, 32'hAA000000, 0, 1, 1,
                     32'h100, 4'h8, 32'h0, 32'h000000AA};
        vecs[10] = '{0, 32'h1, 0, 0, 1, 15, 32'h00007F00, 0, 0, 2,
                     32'h0, 4'h2, 32'h0, 32'h0000007F};

        rst_aH = 1'b1;
        flush = 1'b0;
        head_valid = 1'b0;
        head_is_store = 1'b0;
        head_addr_valid = 1'b0;
        head_st_committed = 1'b0;
        head_addr = '0;
        head_st_data = '0;
        head_size = '0;
        head_sign_ext = 1'b0;
        head_rob_id = '0;
        dc.dc_req_ready = 1'b0;
        dc.dc_resp_valid = 1'b0;
        dc.dc_resp_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_valid", 32'(dc.dc_req_valid), 0);
        chk("rst_req_addr", dc.dc_req_addr, 0);
        chk("rst_req_wmask", 32'(dc.dc_req_wmask), 0);
        chk("rst_deq", 32'(deq_valid), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        rst_aH = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) do_access(vecs[i]);

        // flush while requesting: request withdrawn, nothing accepted
        set_head(0, 32'h400, 0, 2, 0, 20);
        head_st_committed = 1'b0;
        dc.dc_req_ready = 1'b0;
        wait_req(ok);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        head_valid = 1'b0;
        chk("flush_req_valid", 32'(dc.dc_req_valid), 0);
        chk("flush_req_busy", 32'(busy), 0);
        @(negedge clk);
        chk("flush_req_norelaunch", 32'(dc.dc_req_valid), 0);

        // flush while awaiting response: drain it silently
        set_head(0, 32'h404, 0, 2, 0, 21);
        dc.dc_req_ready = 1'b1;
        wait_req(ok);
        head_valid = 1'b0;
        @(negedge clk);
        dc.dc_req_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_busy", 32'(busy), 1);
        @(negedge clk);
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = 32'hFEEDFACE;
        @(negedge clk);
        dc.dc_resp_valid = 1'b0;
        chk("drain_deq", 32'(deq_valid), 0);
        chk("drain_wb", 32'(wb_valid), 0);
        chk("drain_idle", 32'(busy), 0);

        // reset mid-access: immediate clear, late response ignored
        set_head(0, 32'h408, 0, 2, 0, 22);
        dc.dc_req_ready = 1'b1;
        wait_req(ok);
        head_valid = 1'b0;
        @(negedge clk);
        dc.dc_req_ready = 1'b0;
        rst_aH = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_req_valid", 32'(dc.dc_req_valid), 0);
        chk("arst_req_addr", dc.dc_req_addr, 0);
        chk("arst_wb_data", wb_data, 0);
        @(negedge clk);
        rst_aH = 1'b0;
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = 32'h01020304;
        @(negedge clk);
        dc.dc_resp_valid = 1'b0;
        chk("late_resp_deq", 32'(deq_valid), 0);
        chk("late_resp_wb", 32'(wb_valid), 0);
        chk("late_resp_busy", 32'(busy), 0);

        // back-to-back loads: stale head held through the retire cycle
        set_head(0, 32'h300, 0, 2, 0, 7);
        dc.dc_req_ready = 1'b1;
        wait_req(ok);
        sbq.push_back('{5'd7, 32'h11223344});
        @(negedge clk);
        dc.dc_req_ready = 1'b0;
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = 32'h11223344;
        @(negedge clk);
        dc.dc_resp_valid = 1'b0;
        chk("b2b_deq", 32'(deq_valid), 1);
        chk("b2b_no_req_in_deq", 32'(dc.dc_req_valid), 0);
        @(posedge clk);
        #1;
        set_head(0, 32'h304, 0, 2, 0, 8);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_second_req", 32'(dc.dc_req_valid), 1);
        chk("b2b_second_addr", dc.dc_req_addr, 32'h304);
        sbq.push_back('{5'd8, 32'h55667788});
        dc.dc_req_ready = 1'b1;
        @(negedge clk);
        dc.dc_req_ready = 1'b0;
        head_valid = 1'b0;
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = 32'h55667788;
        @(negedge clk);
        dc.dc_resp_valid = 1'b0;
        chk("b2b_second_deq", 32'(deq_valid), 1);
        @(negedge clk);
        chk("b2b_deq_end", 32'(deq_valid), 0);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
